// File: rtl/bcd_time_loader.sv
// Loads an hh:mm:ss time given as BCD digits into binary registers.
// Inputs are range-checked first, then converted by a 7-step reverse double-dabble.
//
// state | meaning
// IDLE  | waiting for start; digits latched on the accepting edge
// CHECK | range-check the latched digits; reject or seed the work registers
// SHIFT | seven reverse double-dabble iterations on all three fields
// LOAD  | copy binary results to the outputs and pulse done
module bcd_time_loader #(
    parameter int MAX_HORA   = 23,
    parameter int MAX_MINSEG = 59
) (
    input  logic       clk_c,
    input  logic       rst_c,
    input  logic       start,
    input  logic [3:0] hora2,
    input  logic [3:0] hora1,
    input  logic [3:0] min2,
    input  logic [3:0] min1,
    input  logic [3:0] seg2,
    input  logic [3:0] seg1,
    output logic [5:0] horas,
    output logic [5:0] minutos,
    output logic [5:0] segundos,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        LOAD  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_H  = 8'(MAX_HORA);
    localparam logic [7:0] MAX_MS = 8'(MAX_MINSEG);
    localparam logic [2:0] LAST_ITER = 3'd6;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  d_h2, d_h1, d_m2, d_m1, d_s2, d_s1;
    logic [14:0] wr_h, wr_m, wr_s;
    logic [2:0]  iter_cnt;

    logic [7:0]  val_h, val_m, val_s;
    logic        digit_bad;
    logic        range_bad;
    logic        reject;

    // One reverse double-dabble step: shift right, then pull each BCD nibble
    // that reached 8 or more back down by 3.
    function automatic logic [14:0] dd_step(input logic [14:0] r);
        logic [14:0] s;
        s = r >> 1;
        if (s[14:11] >= 4'd8)
            s[14:11] = s[14:11] - 4'd3;
        if (s[10:7] >= 4'd8)
            s[10:7] = s[10:7] - 4'd3;
        return s;
    endfunction

    always_comb begin
        val_h = ({4'd0, d_h2} * 8'd10) + {4'd0, d_h1};
        val_m = ({4'd0, d_m2} * 8'd10) + {4'd0, d_m1};
        val_s = ({4'd0, d_s2} * 8'd10) + {4'd0, d_s1};

        digit_bad = (d_h2 > 4'd9) || (d_h1 > 4'd9) ||
                    (d_m2 > 4'd9) || (d_m1 > 4'd9) ||
                    (d_s2 > 4'd9) || (d_s1 > 4'd9);
        range_bad = (val_h > MAX_H) || (val_m > MAX_MS) || (val_s > MAX_MS);
        reject    = digit_bad || range_bad;
    end

    always_ff @(posedge clk_c or posedge rst_c) begin
        if (rst_c)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? IDLE : SHIFT;
            SHIFT:   if (iter_cnt == LAST_ITER) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_c or posedge rst_c) begin
        if (rst_c) begin
            d_h2     <= '0;
            d_h1     <= '0;
            d_m2     <= '0;
            d_m1     <= '0;
            d_s2     <= '0;
            d_s1     <= '0;
            wr_h     <= '0;
            wr_m     <= '0;
            wr_s     <= '0;
            iter_cnt <= '0;
            horas    <= '0;
            minutos  <= '0;
            segundos <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d_h2 <= hora2;
                        d_h1 <= hora1;
                        d_m2 <= min2;
                        d_m1 <= min1;
                        d_s2 <= seg2;
                        d_s1 <= seg1;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        error <= 1'b1;
                    end else begin
                        wr_h     <= {d_h2, d_h1, 7'b0};
                        wr_m     <= {d_m2, d_m1, 7'b0};
                        wr_s     <= {d_s2, d_s1, 7'b0};
                        iter_cnt <= '0;
                    end
                end
                SHIFT: begin
                    wr_h     <= dd_step(wr_h);
                    wr_m     <= dd_step(wr_m);
                    wr_s     <= dd_step(wr_s);
                    iter_cnt <= iter_cnt + 3'd1;
                end
                LOAD: begin
                    horas    <= wr_h[5:0];
                    minutos  <= wr_m[5:0];
                    segundos <= wr_s[5:0];
                    iter_cnt <= '0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Self-checking bench for bcd_time_loader: directed cases plus randomized
// traffic compared every cycle against a cycle-count behavioural model.
module tb_bcd_time_loader;

    logic       clk_c = 1'b0;
    logic       rst_c = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hora2 = '0, hora1 = '0, min2 = '0, min1 = '0, seg2 = '0, seg1 = '0;
    logic [5:0] horas, minutos, segundos;
    logic       busy, done, error;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;
    int cyc     = 0;
    int start_cyc = 0;
    int last_done_cyc = 0;

    always #5 clk_c = ~clk_c;

    bcd_time_loader dut (
        .clk_c    (clk_c),
        .rst_c    (rst_c),
        .start    (start),
        .hora2    (hora2),
        .hora1    (hora1),
        .min2     (min2),
        .min1     (min1),
        .seg2     (seg2),
        .seg1     (seg1),
        .horas    (horas),
        .minutos  (minutos),
        .segundos (segundos),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always @(posedge clk_c) cyc <= cyc + 1;

    // Behavioural model: a phase counts cycles since the accepting edge.
    // Phase 1 decides accept/reject, phase 9 delivers the decimal values.
    int         m_phase = 0;
    int         m_dig [6];
    logic [5:0] m_h = '0, m_m = '0, m_s = '0;
    logic       m_done = 1'b0, m_err = 1'b0;

    function automatic bit time_ok(input int a, input int b, input int c,
                                   input int d, input int e, input int f);
        if (a > 9 || b > 9 || c > 9 || d > 9 || e > 9 || f > 9) return 1'b0;
        return (a * 10 + b <= 23) && (c * 10 + d <= 59) && (e * 10 + f <= 59);
    endfunction

    always @(posedge clk_c or posedge rst_c) begin
        if (rst_c) begin
            m_phase <= 0;
            m_h     <= '0;
            m_m     <= '0;
            m_s     <= '0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_dig[0] <= int'(hora2);
                    m_dig[1] <= int'(hora1);
                    m_dig[2] <= int'(min2);
                    m_dig[3] <= int'(min1);
                    m_dig[4] <= int'(seg2);
                    m_dig[5] <= int'(seg1);
                    m_phase  <= 1;
                end
            end else if (m_phase == 1) begin
                if (time_ok(m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dig[4], m_dig[5])) begin
                    m_phase <= 2;
                end else begin
                    m_err   <= 1'b1;
                    m_phase <= 0;
                end
            end else if (m_phase < 9) begin
                m_phase <= m_phase + 1;
            end else begin
                m_h     <= 6'(m_dig[0] * 10 + m_dig[1]);
                m_m     <= 6'(m_dig[2] * 10 + m_dig[3]);
                m_s     <= 6'(m_dig[4] * 10 + m_dig[5]);
                m_done  <= 1'b1;
                m_phase <= 0;
            end
        end
    end

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge clk_c);
        n_tests++;
        if (horas !== m_h || minutos !== m_m || segundos !== m_s ||
            busy !== (m_phase != 0) || done !== m_done || error !== m_err) begin
            n_fail++;
            $display("FAIL cycle_model cyc=%0d got %0d:%0d:%0d busy=%b done=%b err=%b expected %0d:%0d:%0d busy=%b done=%b err=%b",
                     cyc, horas, minutos, segundos, busy, done, error,
                     m_h, m_m, m_s, (m_phase != 0), m_done, m_err);
        end
        if (done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc;
        end
        if (error === 1'b1) n_err++;
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_digits(input int a, input int b, input int c,
                              input int d, input int e, input int f);
        hora2 = 4'(a); hora1 = 4'(b);
        min2  = 4'(c); min1  = 4'(d);
        seg2  = 4'(e); seg1  = 4'(f);
    endtask

    task automatic pulse_start(input int a, input int b, input int c,
                               input int d, input int e, input int f);
        set_digits(a, b, c, d, e, f);
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic conv(input int a, input int b, input int c,
                        input int d, input int e, input int f);
        pulse_start(a, b, c, d, e, f);
        set_digits(15, 15, 15, 15, 15, 15);
        repeat (11) tick();
    endtask

    function automatic logic [3:0] rnd_digit(input int hi);
        if ($urandom_range(0, 11) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, hi));
    endfunction

    int nd0, ne0;

    initial begin
        tick();
        tick();
        check_lit("reset_horas", int'(horas), 0);
        check_lit("reset_busy", int'(busy), 0);
        check_lit("reset_done_err", int'({done, error}), 0);
        rst_c = 1'b0;
        tick();

        nd0 = n_done;
        pulse_start(1, 2, 3, 4, 5, 6);
        check_lit("busy_after_e0", int'(busy), 1);
        set_digits(9, 9, 9, 9, 9, 9);
        repeat (11) tick();
        check_lit("load_horas_12", int'(horas), 12);
        check_lit("load_minutos_34", int'(minutos), 34);
        check_lit("load_segundos_56", int'(segundos), 56);
        check_lit("latency_12_34_56", last_done_cyc - start_cyc, 9);
        check_lit("done_once_12_34_56", n_done - nd0, 1);

        conv(2, 3, 5, 9, 5, 9);
        check_lit("max_time", int'({horas, minutos, segundos}), (23 << 12) | (59 << 6) | 59);
        check_lit("latency_max", last_done_cyc - start_cyc, 9);

        conv(1, 2, 3, 4, 5, 6);
        nd0 = n_done;
        ne0 = n_err;
        conv(2, 4, 0, 0, 0, 0);
        conv(1, 2, 3, 4, 5, 10);
        conv(0, 0, 6, 0, 0, 0);
        check_lit("reject_err_count", n_err - ne0, 3);
        check_lit("reject_no_done", n_done - nd0, 0);
        check_lit("reject_keeps_time", int'({horas, minutos, segundos}), (12 << 12) | (34 << 6) | 56);

        nd0 = n_done;
        conv(0, 0, 0, 0, 0, 0);
        check_lit("zero_time", int'({horas, minutos, segundos}), 0);
        check_lit("zero_done_once", n_done - nd0, 1);

        nd0 = n_done;
        pulse_start(1, 2, 3, 4, 5, 6);
        repeat (3) tick();
        set_digits(0, 1, 0, 1, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check_lit("restart_ignored_done", n_done - nd0, 1);
        check_lit("restart_ignored_latency", last_done_cyc - start_cyc, 9);

        nd0 = n_done;
        ne0 = n_err;
        pulse_start(2, 1, 4, 3, 0, 9);
        repeat (5) tick();
        #2 rst_c = 1'b1;
        #1;
        check_lit("midreset_outputs", int'({horas, minutos, segundos}), 0);
        check_lit("midreset_busy", int'(busy), 0);
        tick();
        rst_c = 1'b0;
        repeat (8) tick();
        check_lit("midreset_no_pulse", (n_done - nd0) + (n_err - ne0), 0);
        conv(2, 1, 4, 3, 0, 9);
        check_lit("after_reset_time", int'({horas, minutos, segundos}), (21 << 12) | (43 << 6) | 9);

        nd0 = n_done;
        set_digits(1, 0, 2, 0, 3, 0);
        start = 1'b1;
        repeat (25) tick();
        start = 1'b0;
        repeat (12) tick();
        check_lit("held_start_done_count", n_done - nd0, 3);

        for (int i = 0; i < 150; i++) begin
            hora2 = rnd_digit(($urandom_range(0, 3) == 0) ? 9 : 2);
            hora1 = rnd_digit(9);
            min2  = rnd_digit(($urandom_range(0, 3) == 0) ? 9 : 5);
            min1  = rnd_digit(9);
            seg2  = rnd_digit(($urandom_range(0, 3) == 0) ? 9 : 5);
            seg1  = rnd_digit(9);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, 14)); k++) begin
                hora2 = 4'($urandom_range(0, 15));
                seg1  = 4'($urandom_range(0, 15));
                start = ($urandom_range(0, 5) == 0);
                tick();
                start = 1'b0;
            end
        end
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_time_loader.md
BCD_TIME_LOADER -- requirements
Module: bcd_time_loader

Interface
REQ-001 Parameter MAX_HORA, default 23: largest hour value accepted.
REQ-002 Parameter MAX_MINSEG, default 59: largest minute and second value accepted.
REQ-003 clk_c  input  1: sole clock; all state changes on its rising edge.
REQ-004 rst_c  input  1: asynchronous, active-high reset.
REQ-005 start  input  1: load request; sampled only in IDLE.
REQ-006 hora2, hora1, min2, min1, seg2, seg1  input  4 each: BCD tens and units digits for hours, minutes and seconds.
REQ-007 horas, minutos, segundos  output  6 each: registered binary time values.
REQ-008 busy  output  1: high while a conversion is in progress.
REQ-009 done  output  1: one-cycle pulse when new values are loaded.
REQ-010 error  output  1: one-cycle pulse when the input is rejected.

Function
REQ-011 The FSM SHALL use the states IDLE, CHECK, SHIFT and LOAD.
REQ-012 IDLE: if start=1 at edge E0, latch all six digits, set busy=1 and go to CHECK; otherwise stay in IDLE.
REQ-013 CHECK, evaluated at E1, rejects the load if any of these hold:
- any digit > 9;
- hora2*10+hora1 > MAX_HORA;
- min or seg value > MAX_MINSEG.
REQ-014 On rejection, error=1 for the cycle after E1, busy=0, next state is IDLE, and horas/minutos/segundos are unchanged.
REQ-015 On acceptance at E1, load three 15-bit work registers as {tens, units, 7'b0} and go to SHIFT with the iteration counter at 0.
REQ-016 SHIFT performs a reverse double-dabble on all three registers in parallel, one iteration per edge, E2..E8 (7 iterations). Each iteration:
- shift the register right by 1;
- subtract 3 from each 4-bit BCD nibble that is now >= 8.
REQ-017 After the 7th iteration (E8), the next state is LOAD.
REQ-018 LOAD at E9:
- horas/minutos/segundos take the low 6 bits of the 7-bit binary fields;
- done=1 for exactly the cycle following E9;
- busy=0;
- return to IDLE.
REQ-019 Latency from the start-sampling edge to done high is 9 clk_c cycles, fixed and independent of the data value.
REQ-020 start SHALL be ignored while busy=1; no request is queued.
REQ-021 done and error SHALL never be high in the same cycle.
REQ-022 The digit inputs may change after E0 without affecting the conversion in progress.
REQ-023 A start held high continuously SHALL begin a new conversion at the first IDLE edge after the previous one completes.
REQ-024 Outputs SHALL change only at LOAD or on reset.

Reset
REQ-025 While rst_c=1, regardless of clock, the block SHALL hold:
- horas=minutos=segundos=0;
- busy=0, done=0, error=0;
- FSM=IDLE, counter=0, work registers=0.
REQ-026 A reset during CHECK, SHIFT or LOAD SHALL abort the conversion, with no done or error pulse.
REQ-027 The first start is sampled at the first rising edge after rst_c falls.

Verification
REQ-028 Digits 1,2:3,4:5,6, start pulse at E0 -> busy high E0..E9; done at E9; horas=12, minutos=34, segundos=56.
REQ-029 Digits 2,3:5,9:5,9 -> horas=23, minutos=59, segundos=59; done 9 cycles after start.
REQ-030 Out-of-range inputs -> error pulse at E1, done never asserted, outputs keep the prior 12/34/56:
- 2,4:0,0:0,0;
- seg1=4'hA;
- 0,0:6,0:0,0.
REQ-031 Digits 0,0:0,0:0,0 after a prior load -> outputs become 0 at E9 and done pulses once.
REQ-032 A second start pulse at E4 during a conversion -> ignored: single done at E9, no second conversion.
REQ-033 Reset asserted between clock edges at E5 -> outputs 0 and busy 0 immediately, no done; next start converts normally.
